// File: rtl/conv_pkg.sv
// Shared types, widths and helpers for the 3x3 convolution stage.
package conv_pkg;

   localparam int unsigned PIX_W   = 8;
   localparam int unsigned KDIM    = 3;
   localparam int unsigned COEFF_W = 8;
   localparam int unsigned PROD_W  = 17;
   localparam int unsigned ACC_W   = 21;
   localparam int          MAX_SHIFT = 20;

   typedef logic [KDIM-1:0][PIX_W-1:0] pixel_col_t;
   typedef logic signed [KDIM-1:0][KDIM-1:0][COEFF_W-1:0] kernel_t;

   // Negative shifts mean "no shift"; anything past MAX_SHIFT saturates.
   function automatic logic [4:0] eff_shift(input logic signed [7:0] s);
      logic [4:0] r;
      if (s < 8'sd0) begin
         r = '0;
      end else if (int'(s) > MAX_SHIFT) begin
         r = 5'(MAX_SHIFT);
      end else begin
         r = s[4:0];
      end
      return r;
   endfunction

   function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] v);
      logic [PIX_W-1:0] r;
      if (v < 0) begin
         r = '0;
      end else if (v > 21'sd255) begin
         r = '1;
      end else begin
         r = v[PIX_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/convolution_3x3.sv
// Streaming 3x3 convolution: sliding window, per-tap multiply, sum, shift and clamp.
// Four register stages; outputs hold between valid results.
module convolution_3x3
   import conv_pkg::*;
#(
   parameter int unsigned HCOUNT_W = 11,
   parameter int unsigned VCOUNT_W = 10
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                data_valid_in,
   input  pixel_col_t          data_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   input  kernel_t             coeffs_in,
   input  logic signed [7:0]   shift_in,
   output logic                data_valid_out,
   output logic [PIX_W-1:0]    data_out,
   output logic [HCOUNT_W-1:0] hcount_out,
   output logic [VCOUNT_W-1:0] vcount_out
);

   logic [KDIM-1:0][KDIM-1:0][PIX_W-1:0]  window_q, window_d;
   kernel_t                               coeffs_q, coeffs_d;
   logic [KDIM-1:0][KDIM-1:0][PROD_W-1:0] prod_q, prod_d;
   logic signed [ACC_W-1:0]               sum_q, sum_d;

   logic                valid1_q, valid1_d, valid2_q, valid2_d, valid3_q, valid3_d;
   logic                valid_out_q, valid_out_d;
   logic signed [7:0]   shift1_q, shift1_d, shift2_q, shift2_d, shift3_q, shift3_d;
   logic [HCOUNT_W-1:0] hcount1_q, hcount1_d, hcount2_q, hcount2_d, hcount3_q, hcount3_d;
   logic [HCOUNT_W-1:0] hcount_out_q, hcount_out_d;
   logic [VCOUNT_W-1:0] vcount1_q, vcount1_d, vcount2_q, vcount2_d, vcount3_q, vcount3_d;
   logic [VCOUNT_W-1:0] vcount_out_q, vcount_out_d;
   logic [PIX_W-1:0]    data_out_q, data_out_d;

   logic signed [PROD_W-1:0] coef_ext, pix_ext;
   logic signed [ACC_W-1:0]  acc, shifted;

   // Stage 1: window shift plus per-beat capture of kernel, shift and coordinates.
   always_comb begin
      window_d  = window_q;
      coeffs_d  = coeffs_q;
      shift1_d  = shift1_q;
      hcount1_d = hcount1_q;
      vcount1_d = vcount1_q;
      valid1_d  = data_valid_in;
      if (data_valid_in) begin
         for (int unsigned r = 0; r < KDIM; r++) begin
            window_d[r][0] = window_q[r][1];
            window_d[r][1] = window_q[r][2];
            window_d[r][2] = data_in[r];
         end
         coeffs_d  = coeffs_in;
         shift1_d  = shift_in;
         hcount1_d = hcount_in;
         vcount1_d = vcount_in;
      end
   end

   // Stage 2: pixels are zero-extended so the multiply stays signed.
   always_comb begin
      prod_d    = prod_q;
      shift2_d  = shift2_q;
      hcount2_d = hcount2_q;
      vcount2_d = vcount2_q;
      valid2_d  = valid1_q;
      coef_ext  = '0;
      pix_ext   = '0;
      if (valid1_q) begin
         for (int unsigned r = 0; r < KDIM; r++) begin
            for (int unsigned c = 0; c < KDIM; c++) begin
               coef_ext     = PROD_W'($signed(coeffs_q[r][c]));
               pix_ext      = PROD_W'($signed({1'b0, window_q[r][c]}));
               prod_d[r][c] = coef_ext * pix_ext;
            end
         end
         shift2_d  = shift1_q;
         hcount2_d = hcount1_q;
         vcount2_d = vcount1_q;
      end
   end

   // Stage 3: sum of nine products.
   always_comb begin
      sum_d     = sum_q;
      shift3_d  = shift3_q;
      hcount3_d = hcount3_q;
      vcount3_d = vcount3_q;
      valid3_d  = valid2_q;
      acc       = '0;
      if (valid2_q) begin
         for (int unsigned r = 0; r < KDIM; r++) begin
            for (int unsigned c = 0; c < KDIM; c++) begin
               acc = acc + ACC_W'($signed(prod_q[r][c]));
            end
         end
         sum_d     = acc;
         shift3_d  = shift2_q;
         hcount3_d = hcount2_q;
         vcount3_d = vcount2_q;
      end
   end

   // Stage 4: shift, clamp and present.
   always_comb begin
      data_out_d   = data_out_q;
      hcount_out_d = hcount_out_q;
      vcount_out_d = vcount_out_q;
      valid_out_d  = valid3_q;
      shifted      = sum_q >>> eff_shift(shift3_q);
      if (valid3_q) begin
         data_out_d   = clamp_pix(shifted);
         hcount_out_d = hcount3_q;
         vcount_out_d = vcount3_q;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         window_q     <= '0;
         coeffs_q     <= '0;
         prod_q       <= '0;
         sum_q        <= '0;
         valid1_q     <= 1'b0;
         valid2_q     <= 1'b0;
         valid3_q     <= 1'b0;
         valid_out_q  <= 1'b0;
         shift1_q     <= '0;
         shift2_q     <= '0;
         shift3_q     <= '0;
         hcount1_q    <= '0;
         hcount2_q    <= '0;
         hcount3_q    <= '0;
         hcount_out_q <= '0;
         vcount1_q    <= '0;
         vcount2_q    <= '0;
         vcount3_q    <= '0;
         vcount_out_q <= '0;
         data_out_q   <= '0;
      end else begin
         window_q     <= window_d;
         coeffs_q     <= coeffs_d;
         prod_q       <= prod_d;
         sum_q        <= sum_d;
         valid1_q     <= valid1_d;
         valid2_q     <= valid2_d;
         valid3_q     <= valid3_d;
         valid_out_q  <= valid_out_d;
         shift1_q     <= shift1_d;
         shift2_q     <= shift2_d;
         shift3_q     <= shift3_d;
         hcount1_q    <= hcount1_d;
         hcount2_q    <= hcount2_d;
         hcount3_q    <= hcount3_d;
         hcount_out_q <= hcount_out_d;
         vcount1_q    <= vcount1_d;
         vcount2_q    <= vcount2_d;
         vcount3_q    <= vcount3_d;
         vcount_out_q <= vcount_out_d;
         data_out_q   <= data_out_d;
      end
   end

   assign data_valid_out = valid_out_q;
   assign data_out       = data_out_q;
   assign hcount_out     = hcount_out_q;
   assign vcount_out     = vcount_out_q;

endmodule

// File: tb/tb_convolution_3x3.sv
// Scoreboard bench for convolution_3x3: an integer window model predicts each result
// when its beat is driven; results are popped and compared as data_valid_out fires.
module tb_convolution_3x3;
   import conv_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vin = 1'b0;
   pixel_col_t din = '0;
   logic [10:0] hin = '0;
   logic [9:0]  vcin = '0;
   kernel_t     coeffs = '0;
   logic signed [7:0] shift = '0;
   logic        dvout;
   logic [7:0]  dout;
   logic [10:0] hout;
   logic [9:0]  vcout;

   typedef struct {int d; int h; int v;} exp_t;
   exp_t sb[$];
   int   m_win[3][3];
   bit   hist[4];
   bit   exp_v;
   int   n_tests = 0;
   int   n_fail = 0;

   convolution_3x3 #(.HCOUNT_W(11), .VCOUNT_W(10)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .data_valid_in(vin), .data_in(din),
      .hcount_in(hin), .vcount_in(vcin), .coeffs_in(coeffs), .shift_in(shift),
      .data_valid_out(dvout), .data_out(dout), .hcount_out(hout), .vcount_out(vcout)
   );

   always #5 clk = ~clk;

   // Drive one cycle, update the reference model, advance past the edge.
   task automatic step(input bit v, input int top, input int mid, input int bot,
                       input int h, input int vc);
      int sum, sh, res;
      exp_t e;
      vin = v;
      din[0] = 8'(top); din[1] = 8'(mid); din[2] = 8'(bot);
      hin = 11'(h); vcin = 10'(vc);
      if (v) begin
         for (int r = 0; r < 3; r++) begin
            m_win[r][0] = m_win[r][1];
            m_win[r][1] = m_win[r][2];
         end
         m_win[0][2] = top & 255; m_win[1][2] = mid & 255; m_win[2][2] = bot & 255;
         sum = 0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               sum += int'($signed(coeffs[r][c])) * m_win[r][c];
         sh = int'(shift);
         if (sh < 0) sh = 0;
         if (sh > 20) sh = 20;
         res = sum >>> sh;
         if (res < 0) res = 0;
         if (res > 255) res = 255;
         e.d = res; e.h = h & 2047; e.v = vc & 1023;
         sb.push_back(e);
      end
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = v;
      @(posedge clk);
      #1;
      exp_v = hist[3];
      vin = 1'b0;
   endtask

   task automatic clear_model();
      sb.delete();
      for (int i = 0; i < 4; i++) hist[i] = 1'b0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) m_win[r][c] = 0;
      exp_v = 1'b0;
   endtask

   task automatic test_reset();
      clear_model();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (dvout !== 1'b0 || dout !== 8'd0 || hout !== 11'd0 || vcout !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%0b d=%0d h=%0d vc=%0d want all 0", dvout, dout, hout, vcout);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_identity();
      int mids[6] = '{10, 20, 30, 0, 0, 0};
      bit vals[6] = '{1, 1, 1, 0, 0, 0};
      exp_t e;
      int nres = 0;
      coeffs = '0; coeffs[1][1] = 8'sd1; shift = 8'sd0;
      for (int i = 0; i < 6; i++) begin
         step(vals[i], mids[i] + 7, mids[i], mids[i] + 13, 100 + i, 5);
         n_tests++;
         if (dvout !== exp_v) begin
            n_fail++; $display("FAIL identity_valid step %0d: got %0b want %0b", i, dvout, exp_v);
         end
         if (dvout === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL identity_extra: got result %0d want none", dout);
            end else begin
               e = sb.pop_front();
               nres++;
               if (dout !== 8'(e.d) || hout !== 11'(e.h) || vcout !== 10'(e.v)) begin
                  n_fail++;
                  $display("FAIL identity_data: got d=%0d h=%0d vc=%0d want d=%0d h=%0d vc=%0d",
                           dout, hout, vcout, e.d, e.h, e.v);
               end
               if (nres == 3) begin
                  n_tests++;
                  if (dout !== 8'd20 || hout !== 11'd102 || i != 5) begin
                     n_fail++;
                     $display("FAIL identity_third: got d=%0d h=%0d at step %0d want d=20 h=102 at step 5",
                              dout, hout, i);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_gaussian();
      int g[3] = '{1, 2, 1};
      exp_t e;
      int nres = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) coeffs[r][c] = 8'(g[r] * g[c]);
      shift = 8'sd4;
      for (int i = 0; i < 8; i++) begin
         step(i < 5, 100, 100, 100, 200 + i, 7);
         n_tests++;
         if (dvout !== exp_v) begin
            n_fail++; $display("FAIL gaussian_valid step %0d: got %0b want %0b", i, dvout, exp_v);
         end
         if (dvout === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL gaussian_extra: got result %0d want none", dout);
            end else begin
               e = sb.pop_front();
               nres++;
               if (dout !== 8'(e.d) || hout !== 11'(e.h) || vcout !== 10'(e.v)) begin
                  n_fail++;
                  $display("FAIL gaussian_data: got d=%0d h=%0d vc=%0d want d=%0d h=%0d vc=%0d",
                           dout, hout, vcout, e.d, e.h, e.v);
               end
               if (nres == 5) begin
                  n_tests++;
                  if (dout !== 8'd100) begin
                     n_fail++; $display("FAIL gaussian_steady: got %0d want 100", dout);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_sobel_clamp();
      int w[3] = '{1, 2, 1};
      int cols[9] = '{0, 0, 255, 255, 0, 0, 0, 0, 0};
      exp_t e;
      int nres = 0;
      for (int r = 0; r < 3; r++) begin
         coeffs[r][0] = 8'(w[r]); coeffs[r][1] = 8'sd0; coeffs[r][2] = 8'(-w[r]);
      end
      shift = 8'sd0;
      for (int i = 0; i < 9; i++) begin
         step(i < 6, cols[i], cols[i], cols[i], 300 + i, 9);
         n_tests++;
         if (dvout !== exp_v) begin
            n_fail++; $display("FAIL sobel_valid step %0d: got %0b want %0b", i, dvout, exp_v);
         end
         if (dvout === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL sobel_extra: got result %0d want none", dout);
            end else begin
               e = sb.pop_front();
               nres++;
               if (dout !== 8'(e.d) || hout !== 11'(e.h) || vcout !== 10'(e.v)) begin
                  n_fail++;
                  $display("FAIL sobel_data: got d=%0d h=%0d vc=%0d want d=%0d h=%0d vc=%0d",
                           dout, hout, vcout, e.d, e.h, e.v);
               end
               if (nres == 3 || nres == 6) begin
                  n_tests++;
                  if (dout !== ((nres == 3) ? 8'd0 : 8'd255)) begin
                     n_fail++;
                     $display("FAIL sobel_clamp result %0d: got %0d want %0d", nres, dout,
                              (nres == 3) ? 0 : 255);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_bubbles();
      bit vals[9] = '{1, 0, 1, 1, 0, 1, 0, 0, 0};
      exp_t e;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) coeffs[r][c] = 8'(r * 3 + c - 4);
      shift = 8'sd1;
      for (int i = 0; i < 9; i++) begin
         step(vals[i], 40 + 3 * i, 10 * (i + 1), 200 - 7 * i, 400 + i, 11);
         n_tests++;
         if (dvout !== exp_v) begin
            n_fail++; $display("FAIL bubbles_valid step %0d: got %0b want %0b", i, dvout, exp_v);
         end
         if (dvout === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL bubbles_extra: got result %0d want none", dout);
            end else begin
               e = sb.pop_front();
               if (dout !== 8'(e.d) || hout !== 11'(e.h) || vcout !== 10'(e.v)) begin
                  n_fail++;
                  $display("FAIL bubbles_data: got d=%0d h=%0d vc=%0d want d=%0d h=%0d vc=%0d",
                           dout, hout, vcout, e.d, e.h, e.v);
               end
            end
         end
      end
   endtask

   task automatic test_shift_range();
      int shifts[10] = '{-3, -3, -3, 25, 25, 25, 17, 0, 0, 0};
      int want[6] = '{-1, -1, 40, -1, -1, 0};
      exp_t e;
      int nres = 0;
      for (int i = 0; i < 10; i++) begin
         if (i < 3) begin
            coeffs = '0; coeffs[1][1] = 8'sd1;
         end else begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++) coeffs[r][c] = 8'sd127;
         end
         shift = 8'(shifts[i]);
         step(i < 7, (i < 3) ? 40 : 255, (i < 3) ? 40 : 255, (i < 3) ? 40 : 255, 500 + i, 13);
         n_tests++;
         if (dvout !== exp_v) begin
            n_fail++; $display("FAIL shift_valid step %0d: got %0b want %0b", i, dvout, exp_v);
         end
         if (dvout === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL shift_extra: got result %0d want none", dout);
            end else begin
               e = sb.pop_front();
               nres++;
               if (dout !== 8'(e.d) || hout !== 11'(e.h) || vcout !== 10'(e.v)) begin
                  n_fail++;
                  $display("FAIL shift_data: got d=%0d h=%0d vc=%0d want d=%0d h=%0d vc=%0d",
                           dout, hout, vcout, e.d, e.h, e.v);
               end
               if (nres <= 6 && want[nres-1] >= 0) begin
                  n_tests++;
                  if (dout !== 8'(want[nres-1])) begin
                     n_fail++; $display("FAIL shift_bound result %0d: got %0d want %0d", nres, dout, want[nres-1]);
                  end
               end
               if (nres == 7) begin
                  n_tests++;
                  if (dout !== 8'd2) begin
                     n_fail++; $display("FAIL shift_17: got %0d want 2", dout);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_async_reset();
      int mids[10] = '{50, 60, 70, 80, 90, 91, 92, 0, 0, 0};
      exp_t e;
      int nres = 0;
      coeffs = '0; coeffs[1][1] = 8'sd1; shift = 8'sd0;
      for (int i = 0; i < 10; i++) begin
         step(i < 7, mids[i] + 1, mids[i], mids[i] + 2, 600 + i, 15);
         n_tests++;
         if (dvout !== exp_v) begin
            n_fail++; $display("FAIL areset_valid step %0d: got %0b want %0b", i, dvout, exp_v);
         end
         if (dvout === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL areset_extra: got result %0d h=%0d want none", dout, hout);
            end else begin
               e = sb.pop_front();
               nres++;
               if (dout !== 8'(e.d) || hout !== 11'(e.h) || vcout !== 10'(e.v)) begin
                  n_fail++;
                  $display("FAIL areset_data: got d=%0d h=%0d vc=%0d want d=%0d h=%0d vc=%0d",
                           dout, hout, vcout, e.d, e.h, e.v);
               end
               if (i >= 4 && (nres == 2 || nres == 3)) begin
                  n_tests++;
                  if (dout !== ((nres == 2) ? 8'd0 : 8'd90)) begin
                     n_fail++;
                     $display("FAIL areset_zero_fill result %0d: got %0d want %0d", nres, dout,
                              (nres == 2) ? 0 : 90);
                  end
               end
            end
         end
         if (i == 3) begin
            // Three beats still in flight; reset lands between edges.
            #2;
            rst_n = 1'b0;
            #1;
            n_tests++;
            if (dvout !== 1'b0 || dout !== 8'd0 || hout !== 11'd0 || vcout !== 10'd0) begin
               n_fail++;
               $display("FAIL areset_async: got v=%0b d=%0d h=%0d vc=%0d want all 0", dvout, dout, hout, vcout);
            end
            clear_model();
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
   endtask

   task automatic test_random();
      exp_t e;
      bit v;
      for (int i = 0; i < 43; i++) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) coeffs[r][c] = 8'($urandom);
         shift = 8'(int'($urandom_range(0, 29)) - 5);
         v = (i < 40) && ($urandom_range(0, 9) < 7);
         step(v, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
         n_tests++;
         if (dvout !== exp_v) begin
            n_fail++; $display("FAIL random_valid step %0d: got %0b want %0b", i, dvout, exp_v);
         end
         if (dvout === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL random_extra: got result %0d want none", dout);
            end else begin
               e = sb.pop_front();
               if (dout !== 8'(e.d) || hout !== 11'(e.h) || vcout !== 10'(e.v)) begin
                  n_fail++;
                  $display("FAIL random_data step %0d: got d=%0d h=%0d vc=%0d want d=%0d h=%0d vc=%0d",
                           i, dout, hout, vcout, e.d, e.h, e.v);
               end
            end
         end
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL random_drain: got %0d results pending want 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_gaussian();
      test_sobel_clamp();
      test_bubbles();
      test_shift_range();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
